imem_arbiter: RTL

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter_if.sv | 36 +++
 rtl/imem_arbiter.sv | 109 ++++++++++
 2 files changed

// File: rtl/imem_arbiter_if.sv
// Shared instruction-memory bus: core fetch port, loader/debug port and memory side.
// The arbiter takes the slave view; the environment (core, loader, memory) takes the master view.
interface imem_arbiter_if #(
  parameter int AW = 8
);
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic          fetch_gnt;
  logic          fetch_rvalid;
  logic [31:0]   fetch_rdata;
  logic          ldr_req;
  logic          ldr_we;
  logic [31:0]   ldr_addr;
  logic [31:0]   ldr_wdata;
  logic          ldr_lock;
  logic          ldr_gnt;
  logic          ldr_rvalid;
  logic [31:0]   ldr_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr, ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock, mem_rdata,
    output fetch_gnt, fetch_rvalid, fetch_rdata, ldr_gnt, ldr_rvalid, ldr_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output fetch_req, fetch_addr, ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock, mem_rdata,
    input  fetch_gnt, fetch_rvalid, fetch_rdata, ldr_gnt, ldr_rvalid, ldr_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// Arbiter sharing one single-port instruction memory between the core fetch port and a
// loader/debug port, with fetch starvation protection and an exclusive loader lock.
module imem_arbiter #(
  parameter int AW       = 8,
  parameter int MAX_WAIT = 4
) (
  input logic           clk,
  input logic           rst,
  imem_arbiter_if.slave bus
);
  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam logic [SW-1:0] MAX_W = SW'(MAX_WAIT);

  typedef enum logic [0:0] {RUN = 1'b0, LOAD = 1'b1} state_t;

  state_t        state_r, state_nxt_s;
  logic [SW-1:0] starv_r, starv_nxt_s;
  logic          starved_s;
  logic          fetch_gnt_s, ldr_gnt_s;
  logic          pend_fetch_r, pend_ldr_r;
  logic [31:0]   fetch_hold_r, ldr_hold_r;
  logic          unused_addr_s;

  // State, starvation counter, read-owner tracking and read-data hold registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= RUN;
      starv_r      <= '0;
      pend_fetch_r <= 1'b0;
      pend_ldr_r   <= 1'b0;
      fetch_hold_r <= 32'h0;
      ldr_hold_r   <= 32'h0;
    end else begin
      state_r      <= state_nxt_s;
      starv_r      <= starv_nxt_s;
      pend_fetch_r <= fetch_gnt_s;
      pend_ldr_r   <= ldr_gnt_s & ~bus.ldr_we;
      if (pend_fetch_r) fetch_hold_r <= bus.mem_rdata;
      if (pend_ldr_r)   ldr_hold_r   <= bus.mem_rdata;
    end
  end

  // Grant selection, starvation counting and next-state decision
  always_comb begin
    state_nxt_s = state_r;
    starv_nxt_s = starv_r;
    fetch_gnt_s = 1'b0;
    ldr_gnt_s   = 1'b0;
    starved_s   = (starv_r == MAX_W);
    if (rst) begin
      state_nxt_s = RUN;
      starv_nxt_s = '0;
    end else begin
      case (state_r)
        RUN: begin
          // A pending lock stops new fetches so the hand-over cannot be livelocked
          if (bus.ldr_lock) begin
            ldr_gnt_s = bus.ldr_req;
          end else if (bus.fetch_req && (!bus.ldr_req || starved_s)) begin
            fetch_gnt_s = 1'b1;
          end else begin
            ldr_gnt_s = bus.ldr_req;
          end
          if (!bus.fetch_req || fetch_gnt_s) begin
            starv_nxt_s = '0;
          end else if (!starved_s) begin
            starv_nxt_s = starv_r + {{(SW-1){1'b0}}, 1'b1};
          end else begin
            starv_nxt_s = starv_r;
          end
          if (bus.ldr_lock && !pend_fetch_r) begin
            state_nxt_s = LOAD;
          end else begin
            state_nxt_s = RUN;
          end
        end
        LOAD: begin
          ldr_gnt_s   = bus.ldr_req;
          starv_nxt_s = '0;
          if (bus.ldr_lock) begin
            state_nxt_s = LOAD;
          end else begin
            state_nxt_s = RUN;
          end
        end
        default: begin
          state_nxt_s = RUN;
          starv_nxt_s = '0;
        end
      endcase
    end
  end

  assign bus.fetch_gnt = fetch_gnt_s;
  assign bus.ldr_gnt   = ldr_gnt_s;
  assign bus.mem_en    = fetch_gnt_s | ldr_gnt_s;
  assign bus.mem_we    = bus.ldr_we & ldr_gnt_s;
  assign bus.mem_addr  = ldr_gnt_s ? bus.ldr_addr[AW+1:2] : bus.fetch_addr[AW+1:2];
  assign bus.mem_wdata = bus.ldr_wdata;

  // Read data is live in the response cycle, otherwise the last captured word
  assign bus.fetch_rvalid = pend_fetch_r & ~rst;
  assign bus.ldr_rvalid   = pend_ldr_r & ~rst;
  assign bus.fetch_rdata  = rst ? 32'h0 : (pend_fetch_r ? bus.mem_rdata : fetch_hold_r);
  assign bus.ldr_rdata    = rst ? 32'h0 : (pend_ldr_r ? bus.mem_rdata : ldr_hold_r);

  assign unused_addr_s = ^{bus.fetch_addr[31:AW+2], bus.fetch_addr[1:0],
                           bus.ldr_addr[31:AW+2], bus.ldr_addr[1:0]};
endmodule
